// File: rtl/demux1x4_tdm.sv
// rtl/demux1x4_tdm.sv - 1:4 time-division demultiplexer with sync framing
//
// Purpose:
//   Splits one serial sample stream into four registered channel outputs.
//   A sync marker on a valid sample identifies the channel-0 sample and starts
//   a frame. A slot counter then steps through channels 0..3 and wraps.
//   Each channel output holds its value until its slot is written again.
//   Per-channel strobes pulse on every write. frame_valid pulses when slot 3
//   completes a frame. frame_err pulses when a sync arrives mid-frame.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   din          in   WIDTH  serial sample
//   din_valid    in   1      din carries a sample this cycle
//   sync         in   1      marks din as the channel-0 sample (only with din_valid)
//   o0..o3       out  WIDTH  registered channel outputs, slot 0..3
//   strobe       out  4      one-hot pulse, bit n high the cycle o<n> is (re)loaded
//   frame_valid  out  1      1-cycle pulse when slot 3 is written
//   frame_err    out  1      1-cycle pulse when sync arrives while slot != 0 (locked)
//   locked       out  1      high while in the LOCKED state
//   slot         out  2      slot the next accepted sample will be written to

module demux1x4_tdm #(
   parameter int unsigned           WIDTH     = 1,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] o0,
   output logic [WIDTH-1:0] o1,
   output logic [WIDTH-1:0] o2,
   output logic [WIDTH-1:0] o3,
   output logic [3:0]       strobe,
   output logic             frame_valid,
   output logic             frame_err,
   output logic             locked,
   output logic [1:0]       slot
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] o0_q, o1_q, o2_q, o3_q;
   logic [3:0]       strobe_q;
   logic             frame_valid_q;
   logic             frame_err_q;
   logic [1:0]       slot_q;
   logic [1:0]       slot_d;

   // Two-bit counter: slot 3 wraps naturally to 0 for free-running frames.
   assign slot_d = slot_q + 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= HUNT;
         o0_q          <= RESET_VAL;
         o1_q          <= RESET_VAL;
         o2_q          <= RESET_VAL;
         o3_q          <= RESET_VAL;
         strobe_q      <= 4'b0000;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         slot_q        <= 2'd0;
      end else begin
         // Event outputs are single-cycle pulses; default them low.
         strobe_q      <= 4'b0000;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;

         if (din_valid) begin
            case (state_q)
               HUNT: begin
                  // Samples before the first sync cannot be placed in a slot.
                  if (sync) begin
                     o0_q     <= din;
                     strobe_q <= 4'b0001;
                     slot_q   <= 2'd1;
                     state_q  <= LOCKED;
                  end
               end

               LOCKED: begin
                  if (sync) begin
                     // Sync always restarts at slot 0. Arriving mid-frame
                     // abandons the partial frame: o1..o3 keep stale data.
                     o0_q        <= din;
                     strobe_q    <= 4'b0001;
                     slot_q      <= 2'd1;
                     frame_err_q <= (slot_q != 2'd0);
                  end else begin
                     case (slot_q)
                        2'd0:    o0_q <= din;
                        2'd1:    o1_q <= din;
                        2'd2:    o2_q <= din;
                        default: o3_q <= din;
                     endcase
                     strobe_q      <= 4'b0001 << slot_q;
                     slot_q        <= slot_d;
                     frame_valid_q <= (slot_q == 2'd3);
                  end
               end

               default: begin
                  state_q <= HUNT;
                  slot_q  <= 2'd0;
               end
            endcase
         end
      end
   end

   assign o0          = o0_q;
   assign o1          = o1_q;
   assign o2          = o2_q;
   assign o3          = o3_q;
   assign strobe      = strobe_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign locked      = (state_q == LOCKED);
   assign slot        = slot_q;

endmodule
